// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Pulls one character from an upstream FIFO with registered read data and shifts it out
// LSB first as start bit, data bits, optional parity bit and one or two stop bits.
// The serial line is driven from a register, so it never glitches and sits high while idle.
// Every serial bit lasts CLKS_PER_BIT clocks.

module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  // Counter widths. The bit counter also counts stop bits, which never exceed DATA_WIDTH.
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  // FSM encoding
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReq    = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StStart  = 3'd3;
  localparam logic [2:0] StData   = 3'd4;
  localparam logic [2:0] StParity = 3'd5;
  localparam logic [2:0] StStop   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cyc_q, cyc_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
  logic                  timed_state;

  // Last clock of the current serial bit.
  assign bit_end = (cyc_q == CntLast);

  // States in which the line carries a serial bit and the cycle counter runs.
  assign timed_state = (state_q == StStart) || (state_q == StData) ||
                       (state_q == StParity) || (state_q == StStop);

  // Cycle counter: runs within a bit, restarts from zero on every bit boundary.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == StLoad) begin
      cyc_d = '0;
    end else if (timed_state) begin
      cyc_d = bit_end ? '0 : cyc_q + CntW'(1);
    end
  end

  // Next-state, bit counter, shift register and parity.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // fifo_empty is not re-examined: the read has been issued.
        state_d = StLoad;
      end
      StLoad: begin
        // Read data is valid now, one cycle after the strobe.
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ PARITY_ODD;
        bit_d    = '0;
        state_d  = StStart;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line level for the state being entered, so tx is registered yet aligned with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and forces the line high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // Outputs decode the state register directly so reset clears them without a clock.
  assign fifo_rd_en = (state_q == StReq);
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;

  // Read strobe is a single-cycle pulse.
  a_rd_pulse: assert property (@(posedge clk) disable iff (reset) fifo_rd_en |=> !fifo_rd_en);

  // Line is high whenever the block is idle.
  a_idle_line: assert property (@(posedge clk) disable iff (reset) !busy |-> tx);

  // Cycle counter never passes the last clock of a bit.
  a_cyc_range: assert property (@(posedge clk) disable iff (reset) cyc_q <= CntLast);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: one even-parity instance exercises the FIFO handshake, reset
// abort, back-to-back and empty-race cases; three further instances cover odd parity, no parity
// and two stop bits. A monitor decodes tx frames against expectations queued by the stimulus.

module tb_uart_tx_serializer;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;   // bits[i] is the i-th bit on the line, start bit first
    int          nbits;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       m_rst = 1'b1;
  logic       m_empty = 1'b1;
  logic [7:0] m_data = 8'h00;
  logic       v_rst = 1'b1;
  logic       v_empty = 1'b1;
  logic [7:0] v_data = 8'hA5;

  logic [3:0] tx_all, rd_all, busy_all, rst_all;
  assign rst_all = {v_rst, v_rst, v_rst, m_rst};

  uart_tx_serializer #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)
  ) u_dut (
    .clk(clk), .reset(m_rst), .fifo_empty(m_empty), .fifo_data(m_data),
    .fifo_rd_en(rd_all[0]), .tx(tx_all[0]), .busy(busy_all[0])
  );

  uart_tx_serializer #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)
  ) u_odd (
    .clk(clk), .reset(v_rst), .fifo_empty(v_empty), .fifo_data(v_data),
    .fifo_rd_en(rd_all[1]), .tx(tx_all[1]), .busy(busy_all[1])
  );

  uart_tx_serializer #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)
  ) u_nopar (
    .clk(clk), .reset(v_rst), .fifo_empty(v_empty), .fifo_data(v_data),
    .fifo_rd_en(rd_all[2]), .tx(tx_all[2]), .busy(busy_all[2])
  );

  uart_tx_serializer #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)
  ) u_stop2 (
    .clk(clk), .reset(v_rst), .fifo_empty(v_empty), .fifo_data(v_data),
    .fifo_rd_en(rd_all[3]), .tx(tx_all[3]), .busy(busy_all[3])
  );

  // Upstream FIFO model for the main instance: registered read data, empty flag from pointers.
  logic [7:0] fifo_arr [8];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_err = 0;

  always @(posedge clk) begin
    if (rd_all[0]) begin
      if (rd_ptr == wr_ptr) rd_err <= rd_err + 1;
      else begin
        m_data <= fifo_arr[rd_ptr % 8];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  always @(negedge clk) m_empty <= (wr_ptr == rd_ptr);

  // Expected frames per instance (ring written by stimulus, read by monitor).
  frame_t exp_mem [4][8];
  int exp_wr [4] = '{default: 0};
  int exp_rd [4] = '{default: 0};

  // Monitor state.
  frame_t cur [4];
  int pos [4] = '{default: 0};
  bit bad [4] = '{default: 1'b0};
  bit in_fr [4] = '{default: 1'b0};
  bit spur [4] = '{default: 1'b0};
  int mon_bit [4] = '{default: 0};
  int frames_done [4] = '{default: 0};
  int rd_cnt [4] = '{default: 0};
  int last_end [4] = '{default: 0};
  int mon_gap [4] = '{default: 0};
  int cyc = 0;
  int m_checks = 0;
  int m_passes = 0;

  int checks = 0;
  int passes = 0;

  // Frame monitor: every cycle of every bit must match the expected level with busy high.
  initial begin
    int b;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 4; k++) begin
        if (rst_all[k]) begin
          in_fr[k] = 1'b0;
          mon_bit[k] = 0;
        end else begin
          if (rd_all[k]) rd_cnt[k]++;
          if (!in_fr[k] && tx_all[k] === 1'b1) spur[k] = 1'b0;
          if (!in_fr[k] && tx_all[k] !== 1'b1) begin
            if (exp_rd[k] == exp_wr[k]) begin
              if (!spur[k]) begin
                m_checks++;
                $display("FAIL frame_start dut%0d: tx low at cycle %0d, required high (no frame due)",
                         k, cyc);
                spur[k] = 1'b1;
              end
            end else begin
              cur[k] = exp_mem[k][exp_rd[k] % 8];
              exp_rd[k]++;
              in_fr[k] = 1'b1;
              pos[k] = 0;
              bad[k] = 1'b0;
              mon_gap[k] = cyc - last_end[k] - 1;
            end
          end
          if (in_fr[k]) begin
            b = pos[k] / CPB;
            mon_bit[k] = b;
            if (tx_all[k] !== cur[k].bits[b] || busy_all[k] !== 1'b1) bad[k] = 1'b1;
            if (pos[k] % CPB == CPB - 1) begin
              m_checks++;
              if (!bad[k]) m_passes++;
              else $display("FAIL frame_bit dut%0d bit %0d: tx=%b busy=%b, required tx=%b busy=1 for %0d cycles",
                            k, b, tx_all[k], busy_all[k], cur[k].bits[b], CPB);
              bad[k] = 1'b0;
              if (b == cur[k].nbits - 1) begin
                in_fr[k] = 1'b0;
                frames_done[k]++;
                last_end[k] = cyc;
              end
            end
            pos[k]++;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic push_exp(input int k, input logic [15:0] bits, input int nbits);
    exp_mem[k][exp_wr[k] % 8] = '{bits, nbits};
    exp_wr[k]++;
  endtask

  task automatic push_byte(input logic [7:0] d);
    fifo_arr[wr_ptr % 8] = d;
    wr_ptr++;
  endtask

  task automatic wait_frames(input int k, input int target);
    int n = 0;
    while (frames_done[k] < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("frames_done_dut%0d", k), frames_done[k], target);
  endtask

  task automatic wait_bit(input int k, input int b);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(in_fr[k] && mon_bit[k] == b) && n < 400);
    chk($sformatf("reach_bit%0d_dut%0d", b, k), mon_bit[k], b);
  endtask

  // Main instance must stay idle: line high, not busy, no read strobe.
  task automatic quiet(input string name, input int n);
    int nbad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_all[0] !== 1'b1 || busy_all[0] !== 1'b0 || rd_all[0] !== 1'b0) nbad++;
    end
    chk(name, nbad, 0);
  endtask

  initial begin
    int r0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx_all, 4'hF);
    chk("reset_rd_en", rd_all, 4'h0);
    chk("reset_busy", busy_all, 4'h0);
    m_rst = 1'b0;
    v_rst = 1'b0;

    quiet("idle_100", 100);

    // 0xA5 even parity: 0 10100101 0 1
    r0 = rd_cnt[0];
    push_exp(0, 16'b101_0100_1010, 11);
    push_byte(8'hA5);
    wait_frames(0, 1);
    chk("a5_rd_pulses", rd_cnt[0] - r0, 1);
    #1;
    chk("a5_busy_after", busy_all[0], 1'b0);
    chk("a5_tx_after", tx_all[0], 1'b1);

    // Reset during data bit 3 of 0x5A.
    push_exp(0, 16'b100_1011_0100, 11);
    push_byte(8'h5A);
    wait_bit(0, 4);
    #2 m_rst = 1'b1;
    #1;
    chk("midrst_tx", tx_all[0], 1'b1);
    chk("midrst_busy", busy_all[0], 1'b0);
    chk("midrst_rd_en", rd_all[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 m_rst = 1'b0;
    r0 = rd_cnt[0];
    quiet("post_reset_idle", 20);
    chk("post_reset_rd", rd_cnt[0] - r0, 0);
    chk("post_reset_frames", frames_done[0], 1);

    // Back-to-back 0x00 then 0xFF.
    r0 = rd_cnt[0];
    push_exp(0, 16'b100_0000_0000, 11);
    push_exp(0, 16'b101_1111_1110, 11);
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(0, 3);
    chk("b2b_gap", mon_gap[0], 3);
    chk("b2b_rd_pulses", rd_cnt[0] - r0, 2);

    // Empty flag falls during data, rises again during stop: no further read.
    r0 = rd_cnt[0];
    push_exp(0, 16'b101_1000_0110, 11);
    push_byte(8'hC3);
    wait_bit(0, 4);
    push_byte(8'h99);
    wait_bit(0, 10);
    wr_ptr = rd_ptr;
    wait_frames(0, 4);
    quiet("race_idle", 20);
    chk("race_rd_pulses", rd_cnt[0] - r0, 1);

    // Variants, all sending 0xA5.
    push_exp(1, 16'b111_0100_1010, 11);
    push_exp(2, 16'b11_0100_1010, 10);
    push_exp(3, 16'b1101_0100_1010, 12);
    @(posedge clk);
    #1 v_empty = 1'b0;
    @(posedge clk);
    #1 v_empty = 1'b1;
    for (int k = 1; k < 4; k++) wait_frames(k, 1);
    #1;
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("var_rd_pulses_dut%0d", k), rd_cnt[k], 1);
      chk($sformatf("var_busy_after_dut%0d", k), busy_all[k], 1'b0);
    end

    chk("read_while_empty", rd_err, 0);
    chk("frames_expected_consumed", exp_rd[0], exp_wr[0]);

    checks = checks + m_checks;
    passes = passes + m_passes;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per character; must match the width of the upstream FIFO.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter PARITY_EN, default 1: 1 appends a parity bit, 0 omits it.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-006 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port fifo_empty, input, 1: empty flag from the upstream FIFO.
REQ-009 Port fifo_data, input, DATA_WIDTH: registered read data from the upstream FIFO; valid the cycle after a read.
REQ-010 Port fifo_rd_en, output, 1: read strobe to the upstream FIFO.
REQ-011 Port tx, output, 1: serial line; idles high.
REQ-012 Port busy, output, 1: high from the request cycle through the last stop-bit cycle.

Function
REQ-013 The FSM SHALL use states IDLE, REQ, LOAD, START, DATA, PARITY and STOP.
REQ-014 In IDLE with fifo_empty=0, the FSM SHALL move to REQ; with fifo_empty=1 it SHALL remain in IDLE.
REQ-015 fifo_rd_en SHALL be high for exactly one cycle, the REQ cycle, and low in every other state; REQ SHALL always advance to LOAD.
REQ-016 At the end of LOAD, the FSM SHALL capture fifo_data into the shift register, clear the bit counter and move to START.
REQ-017 tx SHALL be a registered output: 0 in START, shift_reg[0] in DATA (LSB first), the parity bit in PARITY, and 1 in STOP, IDLE, REQ and LOAD.
REQ-018 Each of START, each DATA bit, PARITY and each stop bit SHALL last exactly CLKS_PER_BIT cycles, timed by a cycle counter that resets to 0 on every bit boundary.
REQ-019 DATA SHALL shift right once per bit and exit after DATA_WIDTH bits, going to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-020 The parity bit SHALL equal the XOR of all captured data bits, inverted when PARITY_ODD=1.
REQ-021 STOP SHALL last STOP_BITS*CLKS_PER_BIT cycles, then the FSM SHALL return to IDLE.
REQ-022 Frame length SHALL be (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles of tx, plus REQ and LOAD.
REQ-023 Back-to-back characters SHALL be separated by exactly one IDLE cycle, so the gap between the end of a stop bit and the next start bit is 3 cycles.
REQ-024 Changes on fifo_empty SHALL be ignored outside IDLE.
REQ-025 A read SHALL never be issued while fifo_empty=1.
REQ-026 busy SHALL be 0 only in IDLE.

Reset
REQ-027 When reset is asserted, the block SHALL immediately, without waiting for clk, set state=IDLE, tx=1, fifo_rd_en=0, busy=0, and clear all counters and the shift register.
REQ-028 Reset asserted mid-frame SHALL abort the frame; tx SHALL go high at once and no partial character SHALL resume after reset.

Verification
REQ-029 Idle: with CLKS_PER_BIT=4, fifo_empty=1 for 100 cycles -> tx=1, fifo_rd_en=0 and busy=0 throughout.
REQ-030 Single byte: with CLKS_PER_BIT=4, PARITY_EN=1, even parity, fifo_data=0xA5 -> one fifo_rd_en pulse, then tx bits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles, then busy=0.
REQ-031 Odd parity, no-parity and STOP_BITS=2: repeat 0xA5 -> parity bit 1; parity bit absent; stop high for 8 cycles.
REQ-032 Back-to-back: FIFO holds 0x00 then 0xFF -> two frames, exactly 3 tx-high cycles between the first frame's stop bit and the second frame's start bit, and exactly two rd_en pulses.
REQ-033 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 and busy=0 within the same cycle; after release, a new frame starts only if fifo_empty=0.
REQ-034 Empty race: fifo_empty rises during STOP -> no fifo_rd_en pulse, and the FSM stays in IDLE.
